fc_par_mvm: RTL

FC_PAR_MVM -- requirements
Module: fc_par_mvm

---
 rtl/fc_pkg.sv | 40 ++++
 rtl/fc_mac_lane.sv | 48 ++++
 rtl/fc_par_mvm.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared types and helpers for the parallel fully-connected matrix-vector block.
// Holds the controller state encoding and the output saturation/ReLU function.
package fc_pkg;

    typedef enum logic [1:0] {
        LOAD_X  = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } fc_state_e;

    // Wide enough to hold any accumulator this block is instantiated with.
    localparam int SAT_W = 128;

    // Clamp a signed value into a width-bit signed range, then optionally zero negatives.
    function automatic logic signed [SAT_W-1:0] sat_relu(
        input logic signed [SAT_W-1:0] value,
        input int                      width,
        input logic                    relu
    );
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] res;
        one = SAT_W'(1);
        hi  = (one <<< (width - 1)) - one;
        lo  = -(one <<< (width - 1));
        if (value > hi) begin
            res = hi;
        end else if (value < lo) begin
            res = lo;
        end else begin
            res = value;
        end
        if (relu && (res < 0)) begin
            res = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One MAC lane: registered product, accumulator with group clear, and a
// saturating (optionally ReLU) view of the accumulator as the lane result.
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int T = 20,
    parameter int N = 12,
    parameter int R = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                in_valid,
    input  logic signed [T-1:0] w,
    input  logic signed [T-1:0] x,
    output logic signed [T-1:0] y
);

    localparam int ACC_W = 2 * T + $clog2(N);

    logic signed [2*T-1:0]   w_ext;
    logic signed [2*T-1:0]   x_ext;
    logic signed [2*T-1:0]   prod;
    logic                    prod_valid;
    logic signed [ACC_W-1:0] acc;

    assign w_ext = (2 * T)'(w);
    assign x_ext = (2 * T)'(x);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
        end else begin
            prod       <= w_ext * x_ext;
            prod_valid <= in_valid;
            if (clear) begin
                acc <= '0;
            end else if (prod_valid) begin
                acc <= acc + ACC_W'(prod);
            end
        end
    end

    assign y = T'(sat_relu(SAT_W'(acc), T, R != 0));

endmodule

// File: rtl/fc_par_mvm.sv
// Parallel fully-connected layer y = W*x: P lanes each own one weight bank and
// compute P rows per group; x is streamed in, y is streamed out in row order.
module fc_par_mvm #(
    parameter int M = 16,
    parameter int N = 12,
    parameter int T = 20,
    parameter int R = 0,
    parameter int P = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      input_valid,
    output logic                      input_ready,
    input  logic signed [T-1:0]       input_data,
    output logic                      output_valid,
    input  logic                      output_ready,
    output logic signed [T-1:0]       output_data,
    input  logic                      w_wr_en,
    input  logic [$clog2(M*N)-1:0]    w_addr,
    input  logic signed [T-1:0]       w_data,
    output logic                      busy
);

    import fc_pkg::*;

    localparam int G      = M / P;
    localparam int BANK_D = G * N;
    localparam int BAW    = (BANK_D > 1) ? $clog2(BANK_D) : 1;
    localparam int XW     = $clog2(N + 1);
    localparam int XIW    = (N > 1) ? $clog2(N) : 1;
    localparam int CW     = $clog2(N + 2);
    localparam int GW     = (G > 1) ? $clog2(G) : 1;
    localparam int LW     = (P > 1) ? $clog2(P) : 1;

    if (M % P != 0) begin : g_bad_p
        $error("fc_par_mvm: M must be a multiple of P");
    end

    fc_state_e state;
    fc_state_e state_next;

    logic [XW-1:0]       x_cnt;
    logic [CW-1:0]       c_cnt;
    logic [GW-1:0]       grp;
    logic [LW-1:0]       lane_idx;
    logic                in_hs;
    logic                out_hs;
    logic                last_lane;
    logic                last_grp;
    logic                rd_en;
    logic                rd_valid;
    logic                clear_acc;
    logic                w_we;
    logic [LW-1:0]       wr_bank;
    logic [BAW-1:0]      wr_loc;
    logic [BAW-1:0]      rd_loc;
    int                  wr_row;
    int                  wr_col;
    logic signed [T-1:0] x_buf [N];
    logic signed [T-1:0] x_q;
    logic signed [T-1:0] lane_y [P];

    assign input_ready  = (state == LOAD_X) && (x_cnt != XW'(N));
    assign output_valid = (state == DRAIN);
    assign busy         = (state != LOAD_X) || (x_cnt != '0);
    assign in_hs        = input_valid && input_ready;
    assign out_hs       = output_valid && output_ready;
    assign last_lane    = (lane_idx == LW'(P - 1));
    assign last_grp     = (grp == GW'(G - 1));
    assign rd_en        = (state == COMPUTE) && (c_cnt < CW'(N));
    assign clear_acc    = (state == COMPUTE) && (c_cnt == '0);
    assign output_data  = output_valid ? lane_y[lane_idx] : '0;

    // Row r lives in bank r mod P at local row r/P, so a group reads one word per bank.
    always_comb begin
        wr_row  = int'(w_addr) / N;
        wr_col  = int'(w_addr) % N;
        w_we    = w_wr_en && !busy && (int'(w_addr) < M * N);
        wr_bank = LW'(wr_row % P);
        wr_loc  = BAW'((wr_row / P) * N + wr_col);
        rd_loc  = BAW'(int'(grp) * N + int'(c_cnt));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD_X;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD_X: begin
                if (x_cnt == XW'(N)) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (c_cnt == CW'(N + 1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs && last_lane) begin
                    state_next = last_grp ? LOAD_X : COMPUTE;
                end
            end
            default: state_next = LOAD_X;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_cnt    <= '0;
            c_cnt    <= '0;
            grp      <= '0;
            lane_idx <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (state == LOAD_X) begin
                if (x_cnt == XW'(N)) begin
                    x_cnt <= '0;
                end else if (in_hs) begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end
            if (state == COMPUTE) begin
                c_cnt <= (c_cnt == CW'(N + 1)) ? '0 : c_cnt + 1'b1;
            end
            if (out_hs) begin
                if (last_lane) begin
                    lane_idx <= '0;
                    grp      <= last_grp ? '0 : grp + 1'b1;
                end else begin
                    lane_idx <= lane_idx + 1'b1;
                end
            end
        end
    end

    // x buffer and read register carry no reset; a new vector always overwrites x first.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            x_buf[XIW'(x_cnt)] <= input_data;
        end
        if (rd_en) begin
            x_q <= x_buf[XIW'(c_cnt)];
        end
    end

    for (genvar p = 0; p < P; p++) begin : g_lane
        logic signed [T-1:0] mem [BANK_D];
        logic signed [T-1:0] w_q;

        always_ff @(posedge clk) begin
            if (w_we && (wr_bank == LW'(p))) begin
                mem[wr_loc] <= w_data;
            end
            if (rd_en) begin
                w_q <= mem[rd_loc];
            end
        end

        fc_mac_lane #(
            .T(T),
            .N(N),
            .R(R)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear_acc),
            .in_valid (rd_valid),
            .w        (w_q),
            .x        (x_q),
            .y        (lane_y[p])
        );
    end

endmodule
